micro_riscv_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined micro RISC-V core. It decouples PC generation from decode through a DEPTH-entry prefetch FIFO. It talks to instruction memory over a req/gnt/rvalid handshake with up to MAX_OUTSTANDING in-flight reads, and handles branch/jump redirects by flushing the FIFO and discarding stale responses. It replaces the single IF/ID register with its combinational memory read, and adds redirect handling without the NOP-injection path.

---
 rtl/micro_riscv_fetch_unit_if.sv | 25 ++
 rtl/micro_riscv_fetch_unit.sv | 135 +++++++++++++
 tb/tb_micro_riscv_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_riscv_fetch_unit_if.sv
// Instruction-memory bus for the fetch unit: req/gnt request phase, in-order rvalid response phase.
// A request is accepted on a cycle with req && gnt. Each accepted request returns exactly one rvalid, in order, at least one cycle later.
interface micro_riscv_fetch_unit_if;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;

   modport master (
      output instr_req_o,
      output instr_addr_o,
      input  instr_gnt_i,
      input  instr_rvalid_i,
      input  instr_rdata_i
   );

   modport slave (
      input  instr_req_o,
      input  instr_addr_o,
      output instr_gnt_i,
      output instr_rvalid_i,
      output instr_rdata_i
   );
endinterface

// File: rtl/micro_riscv_fetch_unit.sv
// Prefetching instruction-fetch front end: credit-limited request issue, in-order response capture
// into a first-word-fall-through FIFO, and redirect handling that flushes the FIFO and discards stale reads.
module micro_riscv_fetch_unit #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_ADDR      = 32'h0000_0000
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   micro_riscv_fetch_unit_if.master   imem,
   input  logic                       redirect_i,
   input  logic [31:0]                redirect_pc_i,
   input  logic                       halt_i,
   output logic                       if_valid_o,
   input  logic                       if_ready_i,
   output logic [31:0]                if_instr_o,
   output logic [31:0]                if_pc_o,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
   output logic                       busy_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [OW-1:0] out_q, out_d;
   logic [OW-1:0] disc_q, disc_d;
   logic          stall_q, stall_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_mem_q [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];

   logic        credit_ok;
   logic        req;
   logic        grant;
   logic        rsp_ok;
   logic        rsp_drop;
   logic        push;
   logic        pop;
   logic        valid;
   logic [31:0] target_pc;

   assign target_pc = redirect_pc_i & ~32'h3;

   // Credits cover both in-flight reads and occupied slots, so every response has a FIFO slot waiting.
   assign credit_ok = (out_q < OW'(MAX_OUTSTANDING)) &&
                      (({1'b0, count_q} + (CW+1)'(out_q)) < (CW+1)'(DEPTH));

   // A stalled request stays up until granted even if halt arrives; redirect withdraws it immediately.
   assign req   = reset_ni && !redirect_i && (stall_q || (!halt_i && credit_ok));
   assign grant = req && imem.instr_gnt_i;

   // Responses with no read in flight can only be leftovers from before a reset and are ignored.
   assign rsp_ok   = imem.instr_rvalid_i && (out_q != '0);
   assign rsp_drop = rsp_ok && (redirect_i || (disc_q != '0));
   assign push     = rsp_ok && !rsp_drop;

   assign valid = (count_q != '0) && !redirect_i;
   assign pop   = valid && if_ready_i;

   always_comb begin
      out_d      = out_q + OW'(grant) - OW'(rsp_ok);
      disc_d     = disc_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      stall_d    = req && !imem.instr_gnt_i;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (redirect_i) begin
         // Everything still in flight after this edge belongs to the old path, so back-to-back
         // redirects never count the same read twice.
         disc_d     = out_d;
         fetch_pc_d = target_pc;
         resp_pc_d  = target_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (rsp_drop) disc_d = disc_q - OW'(1);
         if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         fetch_pc_q <= RESET_ADDR;
         resp_pc_q  <= RESET_ADDR;
         out_q      <= '0;
         disc_q     <= '0;
         stall_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         disc_q     <= disc_d;
         stall_q    <= stall_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= resp_pc_q;
         instr_mem_q[wr_ptr_q] <= imem.instr_rdata_i;
      end
   end

   assign imem.instr_req_o  = req;
   assign imem.instr_addr_o = fetch_pc_q;
   assign if_valid_o        = valid;
   assign if_instr_o        = valid ? instr_mem_q[rd_ptr_q] : 32'h0;
   assign if_pc_o           = valid ? pc_mem_q[rd_ptr_q] : 32'h0;
   assign fifo_count_o      = count_q;
   assign busy_o            = (out_q != '0);

   full_push_a : assert property (@(posedge clk_i) disable iff (!reset_ni)
      !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_micro_riscv_fetch_unit.sv
// Directed bench for micro_riscv_fetch_unit: memory responds one cycle after grant with rdata = address.
module tb_micro_riscv_fetch_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          cyc;
   } pop_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [2:0]  fifo_count;
   logic        busy;
   logic        rsp_en;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] pend_q[$];
   logic [31:0] gnt_log[$];
   pop_t        pop_log[$];

   always #5 clk = ~clk;

   micro_riscv_fetch_unit_if imem();

   micro_riscv_fetch_unit #(
      .DEPTH(4),
      .MAX_OUTSTANDING(2),
      .RESET_ADDR(32'h0000_0000)
   ) dut (
      .clk_i(clk),
      .reset_ni(reset_n),
      .imem(imem),
      .redirect_i(redirect),
      .redirect_pc_i(redirect_pc),
      .halt_i(halt),
      .if_valid_o(if_valid),
      .if_ready_i(if_ready),
      .if_instr_o(if_instr),
      .if_pc_o(if_pc),
      .fifo_count_o(fifo_count),
      .busy_o(busy)
   );

   // One clock cycle: log this cycle's grant/pop, take the edge, then drive the memory response.
   task automatic step();
      #1;
      if (imem.instr_req_o && imem.instr_gnt_i) begin
         pend_q.push_back(imem.instr_addr_o);
         gnt_log.push_back(imem.instr_addr_o);
      end
      if (if_valid && if_ready) pop_log.push_back('{pc: if_pc, instr: if_instr, cyc: cyc});
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (rsp_en && pend_q.size() > 0) begin
         imem.instr_rvalid_i = 1'b1;
         imem.instr_rdata_i  = pend_q.pop_front();
      end else begin
         imem.instr_rvalid_i = 1'b0;
         imem.instr_rdata_i  = 32'h0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0; if_ready = 1'b0;
      imem.instr_gnt_i = 1'b0; imem.instr_rvalid_i = 1'b0; imem.instr_rdata_i = 32'h0;
      rsp_en = 1'b1;
      pend_q.delete();
      step();
      step();
      pop_log.delete();
      gnt_log.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (imem.instr_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem.instr_req_o); end
      checks++; if (imem.instr_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imem.instr_addr_o); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", if_valid); end
      checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 00000000", if_instr); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", if_pc); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
   endtask

   task automatic test_stream();
      int start;
      do_reset();
      imem.instr_gnt_i = 1'b1; if_ready = 1'b1; reset_n = 1'b1;
      #1;
      checks++; if (imem.instr_req_o !== 1'b1) begin errors++; $display("FAIL stream_first_req got %0b exp 1", imem.instr_req_o); end
      checks++; if (imem.instr_addr_o !== 32'h0) begin errors++; $display("FAIL stream_first_addr got %h exp 00000000", imem.instr_addr_o); end
      start = cyc;
      for (int i = 0; i < 14; i++) step();
      checks++;
      if (pop_log.size() < 8) begin
         errors++; $display("FAIL stream_pops got %0d exp >=8", pop_log.size());
      end else begin
         checks++; if (pop_log[0].cyc !== start + 2) begin errors++; $display("FAIL stream_latency got %0d exp %0d", pop_log[0].cyc - start, 2); end
         for (int i = 0; i < 8; i++) begin
            checks++; if (pop_log[i].pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, pop_log[i].pc, 32'(4 * i)); end
            checks++; if (pop_log[i].instr !== 32'(4 * i)) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, pop_log[i].instr, 32'(4 * i)); end
            checks++; if (pop_log[i].cyc !== pop_log[0].cyc + i) begin errors++; $display("FAIL stream_rate[%0d] got cycle %0d exp %0d", i, pop_log[i].cyc, pop_log[0].cyc + i); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      imem.instr_gnt_i = 1'b1; if_ready = 1'b0; reset_n = 1'b1;
      for (int i = 0; i < 10; i++) step();
      checks++; if (gnt_log.size() !== 4) begin errors++; $display("FAIL bp_grants got %0d exp 4", gnt_log.size()); end
      checks++; if (imem.instr_req_o !== 1'b0) begin errors++; $display("FAIL bp_req got %0b exp 0", imem.instr_req_o); end
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", fifo_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy got %0b exp 0", busy); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc got %h exp 00000000", if_pc); end
      if_ready = 1'b1;
      for (int i = 0; i < 12; i++) step();
      checks++;
      if (pop_log.size() < 5) begin
         errors++; $display("FAIL bp_pops got %0d exp >=5", pop_log.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (pop_log[i].pc !== 32'(4 * i)) begin errors++; $display("FAIL bp_pc[%0d] got %h exp %h", i, pop_log[i].pc, 32'(4 * i)); end
         end
      end
      checks++;
      if (gnt_log.size() < 5) begin
         errors++; $display("FAIL bp_resume got %0d grants exp >=5", gnt_log.size());
      end else if (gnt_log[4] !== 32'h10) begin
         errors++; $display("FAIL bp_resume_addr got %h exp 00000010", gnt_log[4]);
      end
   endtask

   // Leaves the unit with reads to 0x8 and 0xC in flight, FIFO empty, memory holding responses.
   task automatic setup_two_outstanding();
      do_reset();
      imem.instr_gnt_i = 1'b1; if_ready = 1'b1; rsp_en = 1'b1; reset_n = 1'b1;
      step();
      step();
      rsp_en = 1'b0;
      step();
      step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL setup_busy got %0b exp 1", busy); end
      checks++; if (imem.instr_req_o !== 1'b0) begin errors++; $display("FAIL setup_req got %0b exp 0", imem.instr_req_o); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL setup_count got %0d exp 0", fifo_count); end
      pop_log.delete();
   endtask

   task automatic test_redirect();
      setup_two_outstanding();
      rsp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h41;
      #1;
      checks++; if (imem.instr_req_o !== 1'b0) begin errors++; $display("FAIL redir_req got %0b exp 0", imem.instr_req_o); end
      step();
      redirect = 1'b0;
      #1;
      checks++; if (imem.instr_addr_o !== 32'h40) begin errors++; $display("FAIL redir_addr got %h exp 00000040", imem.instr_addr_o); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL redir_busy got %0b exp 1", busy); end
      for (int i = 0; i < 12; i++) step();
      checks++;
      if (pop_log.size() < 2) begin
         errors++; $display("FAIL redir_pops got %0d exp >=2", pop_log.size());
      end else begin
         checks++; if (pop_log[0].pc !== 32'h40) begin errors++; $display("FAIL redir_first_pc got %h exp 00000040", pop_log[0].pc); end
         checks++; if (pop_log[0].instr !== 32'h40) begin errors++; $display("FAIL redir_first_instr got %h exp 00000040", pop_log[0].instr); end
         checks++; if (pop_log[1].pc !== 32'h44) begin errors++; $display("FAIL redir_second_pc got %h exp 00000044", pop_log[1].pc); end
      end
      foreach (pop_log[i]) begin
         checks++;
         if (pop_log[i].pc === 32'h8 || pop_log[i].pc === 32'hC) begin
            errors++; $display("FAIL redir_stale got %h exp not 00000008/0000000c", pop_log[i].pc);
         end
      end
   endtask

   task automatic test_redirect_collide();
      do_reset();
      imem.instr_gnt_i = 1'b1; if_ready = 1'b1; rsp_en = 1'b1; reset_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL coll_count_pre got %0d exp 1", fifo_count); end
      redirect = 1'b1; redirect_pc = 32'h100;
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL coll_valid got %0b exp 0", if_valid); end
      step();
      redirect = 1'b0;
      #1;
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL coll_count got %0d exp 0", fifo_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coll_busy got %0b exp 0", busy); end
      checks++; if (imem.instr_addr_o !== 32'h100) begin errors++; $display("FAIL coll_addr got %h exp 00000100", imem.instr_addr_o); end
      checks++; if (pop_log.size() !== 2) begin errors++; $display("FAIL coll_pre_pops got %0d exp 2", pop_log.size()); end
      pop_log.delete();
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (pop_log.size() < 2) begin
         errors++; $display("FAIL coll_pops got %0d exp >=2", pop_log.size());
      end else begin
         checks++; if (pop_log[0].pc !== 32'h100) begin errors++; $display("FAIL coll_first_pc got %h exp 00000100", pop_log[0].pc); end
         checks++; if (pop_log[1].pc !== 32'h104) begin errors++; $display("FAIL coll_second_pc got %h exp 00000104", pop_log[1].pc); end
      end
   endtask

   task automatic test_back_to_back();
      setup_two_outstanding();
      rsp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect_pc = 32'h300;
      step();
      redirect = 1'b0;
      #1;
      checks++; if (imem.instr_addr_o !== 32'h300) begin errors++; $display("FAIL b2b_addr got %h exp 00000300", imem.instr_addr_o); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0b exp 1", busy); end
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (pop_log.size() < 2) begin
         errors++; $display("FAIL b2b_pops got %0d exp >=2", pop_log.size());
      end else begin
         checks++; if (pop_log[0].pc !== 32'h300) begin errors++; $display("FAIL b2b_first_pc got %h exp 00000300", pop_log[0].pc); end
         checks++; if (pop_log[1].pc !== 32'h304) begin errors++; $display("FAIL b2b_second_pc got %h exp 00000304", pop_log[1].pc); end
      end
   endtask

   task automatic test_halt();
      do_reset();
      imem.instr_gnt_i = 1'b0; if_ready = 1'b1; rsp_en = 1'b1; reset_n = 1'b1;
      step();
      halt = 1'b1;
      #1;
      checks++; if (imem.instr_req_o !== 1'b1) begin errors++; $display("FAIL halt_pending_req got %0b exp 1", imem.instr_req_o); end
      checks++; if (imem.instr_addr_o !== 32'h0) begin errors++; $display("FAIL halt_pending_addr got %h exp 00000000", imem.instr_addr_o); end
      imem.instr_gnt_i = 1'b1;
      step();
      checks++; if (imem.instr_req_o !== 1'b0) begin errors++; $display("FAIL halt_req got %0b exp 0", imem.instr_req_o); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL halt_busy got %0b exp 1", busy); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL halt_busy_fall got %0b exp 0", busy); end
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL halt_valid got %0b exp 1", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL halt_pc got %h exp 00000000", if_pc); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (imem.instr_req_o !== 1'b0) begin errors++; $display("FAIL halt_hold_req[%0d] got %0b exp 0", i, imem.instr_req_o); end
      end
      halt = 1'b0;
      #1;
      checks++; if (imem.instr_req_o !== 1'b1) begin errors++; $display("FAIL halt_resume_req got %0b exp 1", imem.instr_req_o); end
      checks++; if (imem.instr_addr_o !== 32'h4) begin errors++; $display("FAIL halt_resume_addr got %h exp 00000004", imem.instr_addr_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      imem.instr_gnt_i = 1'b1; if_ready = 1'b0; rsp_en = 1'b1; reset_n = 1'b1;
      step();
      step();
      step();
      imem.instr_gnt_i = 1'b0;
      step();
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_count_pre got %0d exp 3", fifo_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_pre got %0b exp 0", busy); end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1; imem.instr_gnt_i = 1'b1;
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b exp 0", if_valid); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", fifo_count); end
      checks++; if (imem.instr_req_o !== 1'b1) begin errors++; $display("FAIL mid_req got %0b exp 1", imem.instr_req_o); end
      checks++; if (imem.instr_addr_o !== 32'h0) begin errors++; $display("FAIL mid_addr got %h exp 00000000", imem.instr_addr_o); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_collide();
      test_back_to_back();
      test_halt();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
